// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - power-up RAM clear plus two-port round-robin access arbiter
module ram_rr_arbiter #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_b;

    // On a tie the requester not served most recently wins.
    always_comb begin
        a_gnt = (state == S_RUN) && a_req && (!b_req || last_b);
        b_gnt = (state == S_RUN) && b_req && (!a_req || !last_b);
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (state == S_INIT) begin
            ram_we   = !rst;
            ram_addr = init_cnt;
            ram_din  = INIT_VAL;
        end else if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            last_b    <= 1'b1;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) a_rdata <= ram_dout;
            if (b_gnt && !b_we) b_rdata <= ram_dout;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == LAST_ADDR) begin
                    state     <= S_RUN;
                    init_done <= 1'b1;
                end
            end else begin
                if (a_gnt)      last_b <= 1'b0;
                else if (b_gnt) last_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - directed bench for ram_rr_arbiter with a behavioural 16x8 RAM
module tb_ram_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       init_done;

    logic [7:0] mem [16];
    logic       tb_we;
    logic [3:0] tb_addr;
    logic [7:0] tb_din;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr] <= ram_din;
        else if (tb_we) mem[tb_addr]  <= tb_din;
    end
    assign ram_dout = mem[ram_addr];

    ram_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .init_done(init_done)
    );

    task automatic test_reset;
        rst = 1'b0; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        tb_we = 0; tb_addr = 0; tb_din = 0;
        #1 rst = 1'b1;
        #1;
        checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, init_done} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {a_gnt, b_gnt, a_rvalid, b_rvalid, init_done}); end
        checks++; if ({a_rdata, b_rdata} !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", {a_rdata, b_rdata}); end
        checks++; if ({ram_we, ram_addr, ram_din} !== 13'h0) begin errors++; $display("FAIL reset_ram: got we=%0d addr=%0d din=%h expected 0 0 00", ram_we, ram_addr, ram_din); end
        // Fill the RAM with garbage under reset so the clear is observable.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_addr = 4'(i); tb_din = 8'hFF;
            #1;
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we_gated: got %0d expected 0", ram_we); end
        end
        @(negedge clk);
        tb_we = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if ({ram_we, ram_addr, ram_din, init_done} !== {1'b1, 4'(i), 8'h00, 1'b0}) begin errors++; $display("FAIL init_step%0d: got we=%0d addr=%0d din=%h done=%0d expected 1 %0d 00 0", i, ram_we, ram_addr, ram_din, init_done, i); end
            @(negedge clk);
        end
        #1;
        checks++; if ({init_done, ram_we} !== 2'b10) begin errors++; $display("FAIL init_done: got done=%0d we=%0d expected 1 0", init_done, ram_we); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem[i] !== 8'h00) begin errors++; $display("FAIL init_clear%0d: got %h expected 00", i, mem[i]); end
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 8'h3C;
        #1;
        checks++; if ({a_gnt, b_gnt, ram_we, ram_addr, ram_din} !== {1'b1, 1'b0, 1'b1, 4'd5, 8'h3C}) begin errors++; $display("FAIL wr_grant: got gnt=%0d%0d we=%0d addr=%0d din=%h expected 10 1 5 3c", a_gnt, b_gnt, ram_we, ram_addr, ram_din); end
        @(negedge clk);
        a_we = 0;
        #1;
        checks++; if ({a_gnt, b_gnt, a_rvalid, ram_we} !== 4'b1000) begin errors++; $display("FAIL rd_grant: got gnt=%0d%0d rvalid=%0d we=%0d expected 10 0 0", a_gnt, b_gnt, a_rvalid, ram_we); end
        @(negedge clk);
        a_req = 0;
        #1;
        checks++; if ({a_rvalid, a_rdata, b_gnt} !== {1'b1, 8'h3C, 1'b0}) begin errors++; $display("FAIL rd_data: got rvalid=%0d rdata=%h bgnt=%0d expected 1 3c 0", a_rvalid, a_rdata, b_gnt); end
        @(negedge clk);
        #1;
        checks++; if ({a_rvalid, a_rdata} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL rd_hold: got rvalid=%0d rdata=%h expected 0 3c", a_rvalid, a_rdata); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 4'd1; b_wdata = 8'h11;
        #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL pre_b1: got %0d expected 1", b_gnt); end
        @(negedge clk);
        b_addr = 4'd2; b_wdata = 8'h22;
        #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL pre_b2: got %0d expected 1", b_gnt); end
        @(negedge clk);
        b_we = 0; a_req = 1; a_we = 0; a_addr = 4'd1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if ({a_gnt, b_gnt} !== {(k % 2 == 0), (k % 2 == 1)}) begin errors++; $display("FAIL rr_gnt%0d: got %0d%0d expected %0d%0d", k, a_gnt, b_gnt, (k % 2 == 0), (k % 2 == 1)); end
            if (k > 0) begin
                checks++; if ({a_rvalid, b_rvalid} !== {(k % 2 == 1), (k % 2 == 0)}) begin errors++; $display("FAIL rr_rvalid%0d: got %0d%0d expected %0d%0d", k, a_rvalid, b_rvalid, (k % 2 == 1), (k % 2 == 0)); end
                checks++; if ((k % 2 == 1) ? (a_rdata !== 8'h11) : (b_rdata !== 8'h22)) begin errors++; $display("FAIL rr_rdata%0d: got a=%h b=%h expected a=11 or b=22", k, a_rdata, b_rdata); end
            end
            @(negedge clk);
        end
        a_req = 0; b_req = 0;
        #1;
        checks++; if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 8'h22}) begin errors++; $display("FAIL rr_last: got rvalid=%0d%0d brdata=%h expected 01 22", a_rvalid, b_rvalid, b_rdata); end
    endtask

    task automatic test_tie_raw;
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 4'd0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL tie_prep: got %0d expected 1", a_gnt); end
        @(negedge clk);
        a_addr = 4'd9;
        b_req = 1; b_we = 1; b_addr = 4'd9; b_wdata = 8'hA5;
        #1;
        checks++; if ({a_gnt, b_gnt, ram_we, ram_addr} !== {2'b01, 1'b1, 4'd9}) begin errors++; $display("FAIL tie_first: got gnt=%0d%0d we=%0d addr=%0d expected 01 1 9", a_gnt, b_gnt, ram_we, ram_addr); end
        @(negedge clk);
        b_req = 0;
        #1;
        checks++; if ({a_gnt, b_gnt, ram_we, ram_addr} !== {2'b10, 1'b0, 4'd9}) begin errors++; $display("FAIL tie_second: got gnt=%0d%0d we=%0d addr=%0d expected 10 0 9", a_gnt, b_gnt, ram_we, ram_addr); end
        @(negedge clk);
        a_req = 0;
        #1;
        checks++; if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 8'hA5}) begin errors++; $display("FAIL tie_rdata: got rvalid=%0d%0d rdata=%h expected 10 a5", a_rvalid, b_rvalid, a_rdata); end
    endtask

    task automatic test_init_hold;
        @(negedge clk);
        rst = 1;
        a_req = 1; a_we = 0; a_addr = 4'd3;
        b_req = 1; b_we = 0; b_addr = 4'd4;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if ({a_gnt, b_gnt, init_done} !== 3'b000) begin errors++; $display("FAIL hold_init%0d: got gnt=%0d%0d done=%0d expected 00 0", i, a_gnt, b_gnt, init_done); end
            @(negedge clk);
        end
        #1;
        checks++; if ({init_done, a_gnt, b_gnt} !== 3'b110) begin errors++; $display("FAIL hold_first: got done=%0d gnt=%0d%0d expected 1 10", init_done, a_gnt, b_gnt); end
        @(negedge clk);
        a_req = 0; b_req = 0;
    endtask

    task automatic test_reset_mid;
        a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 8'h3C;
        @(negedge clk);
        a_we = 0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL mid_rd_gnt: got %0d expected 1", a_gnt); end
        @(negedge clk);
        a_req = 0;
        #1;
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL mid_pre: got rvalid=%0d rdata=%h expected 1 3c", a_rvalid, a_rdata); end
        rst = 1;
        #1;
        checks++; if ({a_rvalid, a_rdata, init_done, ram_we} !== {1'b0, 8'h00, 2'b00}) begin errors++; $display("FAIL mid_rst: got rvalid=%0d rdata=%h done=%0d we=%0d expected 0 00 0 0", a_rvalid, a_rdata, init_done, ram_we); end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if ({ram_we, ram_addr, a_rvalid, a_rdata, init_done} !== {1'b1, 4'(i), 1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL mid_init%0d: got we=%0d addr=%0d rvalid=%0d rdata=%h done=%0d expected 1 %0d 0 00 0", i, ram_we, ram_addr, a_rvalid, a_rdata, init_done, i); end
            @(negedge clk);
        end
        #1;
        checks++; if ({init_done, mem[5]} !== {1'b1, 8'h00}) begin errors++; $display("FAIL mid_done: got done=%0d mem5=%h expected 1 00", init_done, mem[5]); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_tie_raw;
        test_init_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
# ram_rr_arbiter

Two-requester round-robin arbiter and power-up initializer for the 16x8 single-port RAM, which has a synchronous write and an asynchronous read. After reset it clears every RAM location to INIT_VAL. It then shares the RAM's single port between requesters A and B with a valid/grant handshake and registered read-data return. It sits between the two client blocks and the RAM instance and is the RAM's only driver.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 4, RAM address width
- DEPTH, 16, number of RAM words (2**ADDR_W)
- INIT_VAL, 8'h00, value written to every word during initialization

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_req, b_req  in  1  requester wants an access this cycle
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  access address
- a_wdata, b_wdata  in  DATA_W  write data
- a_gnt, b_gnt  out  1  access accepted at this rising edge (combinational)
- a_rvalid, b_rvalid  out  1  one-cycle pulse, read data valid
- a_rdata, b_rdata  out  DATA_W  registered read data, held until the next read for that port
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM asynchronous read data
- init_done  out  1  high once initialization has completed

## Operation
- FSM states: INIT and RUN. Reset enters INIT with init_cnt=0.
- INIT:
  - ram_we=1, ram_addr=init_cnt, ram_din=INIT_VAL.
  - init_cnt increments each edge.
  - On the edge that writes address DEPTH-1, the FSM moves to RUN and init_done is set.
  - No grants are issued; requests are ignored and not queued.
- RUN arbitration, evaluated combinationally each cycle:
  - Only a_req high: grant A.
  - Only b_req high: grant B.
  - Both high: grant the requester that is not the last one served (last_ptr).
  - Neither high: no grant.
- last_ptr resets to B, so A wins the first tie. It updates only on edges where a grant occurs.
- Granted access drives the RAM: ram_addr=x_addr, ram_we=x_we, ram_din=x_wdata.
  - Write commits at the granting edge.
  - Read: ram_dout is captured into x_rdata at the granting edge, and x_rvalid pulses high for the following cycle.
- Idle RUN cycle: ram_we=0, ram_addr=0, ram_din=0.
- A transaction completes on any edge with x_req & x_gnt. A requester holds req/we/addr/wdata stable until it sees gnt. It may keep req high for back-to-back accesses.
- Writes never produce rvalid. A read to a location written on the previous edge returns the new data.

## Timing
- Values while rst is high and immediately after it releases:
  - gnt=0, rvalid=0, rdata=0, init_done=0.
  - ram_we is gated to 0 while rst is high.
  - ram_addr=0, ram_din=INIT_VAL.
- Initialization takes exactly DEPTH cycles. init_done rises after the DEPTH-th edge, and the first grant is possible in that same cycle.
- Grant latency: 0 cycles when uncontended. Under contention a requester waits at most 1 cycle.
- Read latency: rdata/rvalid appear 1 cycle after the granting edge.
- Sustained throughput is 1 access per cycle. Under continuous contention grants alternate A,B,A,B.
- Reset asserted mid-operation:
  - Any in-flight rvalid is dropped and rdata is cleared.
  - The FSM returns to INIT and the RAM is re-cleared.
  - A write granted in the same cycle that rst rises is not guaranteed.

## Test plan
- Reset, then idle: ram_we=1 with ram_addr stepping 0..15, and init_done rises after 16 edges. A direct RAM read of all 16 words then returns 8'h00.
- A writes 8'h3C to address 5, then A reads address 5: a_gnt is high on both cycles, a_rvalid pulses 1 cycle after the read grant, a_rdata=8'h3C, and b_gnt stays 0.
- Both requesters hold a read request for 6 cycles (A addr 1 preloaded 8'h11, B addr 2 preloaded 8'h22): grants run A,B,A,B,A,B, the rvalids alternate, and rdata values are 11 and 22.
- B writes 8'hA5 to address 9 while A reads address 9 in the same cycle (tie, last_ptr=A): B is granted first, A is granted next cycle, and a_rdata=8'hA5.
- Requests held high during INIT: no gnt until init_done, and the first grant goes to A.
- rst pulsed one cycle after a granted read: a_rvalid stays 0, a_rdata=0, init_done falls, and the 16-cycle INIT repeats.
